hh_gate_bank: RTL and testbench

//  Time-multiplexed Hodgkin-Huxley gating-variable bank: holds NCH gate states (m, h, n, ...) and,
//  per integration step, forward-Euler updates each in turn: x += dt*(alpha*(1-x) - beta*x).

---
 rtl/hh_gate_bank.sv | 105 ++++++++++
 tb/tb_hh_gate_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hh_gate_bank.sv
// hh_gate_bank: time-multiplexed forward-Euler update of NCH Hodgkin-Huxley gating variables.
// Optional sticky clamp flags (sat_flags port) when GATE_BANK_SAT_FLAGS_EN is defined.
module hh_gate_bank #(
  parameter int W = 16,
  parameter int FRAC = 10,
  parameter int NCH = 3,
  parameter logic [NCH*W-1:0] INIT = {16'd326, 16'd610, 16'd54},
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      v_in,
  input  logic [W-1:0]      dt,
  output logic              rate_req,
  output logic [CW-1:0]     rate_ch,
  output logic [W-1:0]      rate_v,
  input  logic              rate_valid,
  input  logic [W-1:0]      alpha,
  input  logic [W-1:0]      beta,
  output logic              busy,
  output logic              done,
  output logic [NCH*W-1:0]  gate_x
`ifdef GATE_BANK_SAT_FLAGS_EN
  ,
  output logic [NCH-1:0]    sat_flags
`endif
);
  localparam int PW = 3*W+2;
  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  localparam logic [CW-1:0] LAST = CW'(NCH-1);
  typedef enum logic [2:0] {IDLE, REQ, CALC, WB, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] ch;
  logic [W-1:0] vq, dtq, aq, bq, x, xn;
  logic [2*W-1:0] a, b;
  logic signed [2*W:0] diff, d1;
  logic signed [PW-1:0] d1e, dte, xe, prod, sum;
  logic lo, hi;
  assign x    = gate_x[ch*W +: W];
  assign a    = {{W{1'b0}}, aq} * {{W{1'b0}}, ONE - x};
  assign b    = {{W{1'b0}}, bq} * {{W{1'b0}}, x};
  assign diff = $signed({1'b0, a}) - $signed({1'b0, b});
  assign d1   = diff >>> FRAC;
  // Widen everything to PW so the dt product and the final add cannot overflow.
  assign d1e  = {{(W+1){d1[2*W]}}, d1};
  assign dte  = {{(2*W+2){1'b0}}, dtq};
  assign xe   = {{(2*W+2){1'b0}}, x};
  assign prod = d1e * dte;
  assign sum  = xe + (prod >>> FRAC);
  assign lo   = sum[PW-1];
  assign hi   = !lo && (sum > $signed({{(PW-W){1'b0}}, ONE}));
  assign xn   = lo ? '0 : hi ? ONE : sum[W-1:0];
  assign rate_req = state == REQ;
  assign rate_ch  = ch;
  assign rate_v   = vq;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? REQ : IDLE;
      REQ:     state_n = rate_valid ? CALC : REQ;
      CALC:    state_n = WB;
      WB:      state_n = ch == LAST ? DONE : REQ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ch     <= '0;
      vq     <= '0;
      dtq    <= '0;
      aq     <= '0;
      bq     <= '0;
      gate_x <= INIT;
`ifdef GATE_BANK_SAT_FLAGS_EN
      sat_flags <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        vq  <= v_in;
        dtq <= dt;
        ch  <= '0;
`ifdef GATE_BANK_SAT_FLAGS_EN
        sat_flags <= '0;
`endif
      end
      if (state == REQ && rate_valid) begin
        aq <= alpha;
        bq <= beta;
      end
      if (state == WB) begin
        gate_x[ch*W +: W] <= xn;
        ch <= ch == LAST ? '0 : ch + 1'b1;
`ifdef GATE_BANK_SAT_FLAGS_EN
        if (lo || hi) sat_flags[ch] <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_hh_gate_bank.sv
// tb_hh_gate_bank: directed checks of the gate bank with a behavioural rate table.
module tb_hh_gate_bank;
  logic clk = 0, reset = 1, start = 0, rate_valid, rate_req, busy, done;
  logic [15:0] v_in = 0, dt = 0, alpha, beta, rate_v;
  logic [1:0] rate_ch;
  logic [47:0] gate_x;
`ifdef GATE_BANK_SAT_FLAGS_EN
  logic [2:0] sat_flags;
`endif
  logic [15:0] ta [3];
  logic [15:0] tbt [3];
  int stall_left = 0;
  int n_tests = 0, n_fail = 0;
  int lat;
  logic seen_done;

  hh_gate_bank dut (
    .clk(clk), .reset(reset), .start(start), .v_in(v_in), .dt(dt),
    .rate_req(rate_req), .rate_ch(rate_ch), .rate_v(rate_v), .rate_valid(rate_valid),
    .alpha(alpha), .beta(beta), .busy(busy), .done(done), .gate_x(gate_x)
`ifdef GATE_BANK_SAT_FLAGS_EN
    , .sat_flags(sat_flags)
`endif
  );

  always #5 clk = ~clk;
  assign alpha = ta[rate_ch];
  assign beta  = tbt[rate_ch];
  assign rate_valid = rate_req && !(rate_ch == 2'd1 && stall_left > 0);
  always @(posedge clk) if (rate_req && rate_ch == 2'd1 && stall_left > 0) stall_left <= stall_left - 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_tbl(input logic [15:0] a0, b0, a1, b1, a2, b2);
    ta[0] = a0; tbt[0] = b0; ta[1] = a1; tbt[1] = b1; ta[2] = a2; tbt[2] = b2;
  endtask

  // Start cycle counts as cycle 1; returns the cycle number in which done was seen.
  task automatic run_step(input logic [15:0] v, input logic [15:0] d, output int l);
    @(negedge clk);
    v_in = v; dt = d; start = 1;
    l = 1;
    @(negedge clk);
    start = 0;
    l = 2;
    while (!done && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    set_tbl(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_ch0", gate_x[15:0], 54);
    chk("rst_ch1", gate_x[31:16], 610);
    chk("rst_ch2", gate_x[47:32], 326);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", rate_req, 0);
    chk("rst_rate_v", rate_v, 0);
    reset = 0;
    // zero rates: full handshake, nothing changes
    run_step(16'hFFC0, 102, lat);
    chk("lat_zero", lat, 11);
    chk("zero_ch0", gate_x[15:0], 54);
    chk("zero_ch1", gate_x[31:16], 610);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    // ch0 opens, ch1 closes; check ch0 only moves at its WB edge
    set_tbl(1024, 0, 0, 4096, 0, 0);
    @(negedge clk);
    v_in = 16'd20; dt = 102; start = 1;
    lat = 1;
    seen_done = 0;
    while (lat < 20 && !seen_done) begin
      @(negedge clk);
      start = 0;
      lat++;
      if (lat == 2) chk("rate_v", rate_v, 20);
      if (lat == 4) chk("ch0_before_wb", gate_x[15:0], 54);
      if (lat == 5) chk("ch0_after_wb", gate_x[15:0], 150);
      if (lat == 7) chk("ch1_before_wb", gate_x[31:16], 610);
      seen_done = done;
    end
    chk("lat_step2", lat, 11);
    chk("open_ch0", gate_x[15:0], 150);
    chk("close_ch1", gate_x[31:16], 366);
    chk("hold_ch2", gate_x[47:32], 326);
    // saturation both ways
    set_tbl(16'hFFFF, 0, 0, 16'hFFFF, 0, 0);
    run_step(0, 1023, lat);
    chk("lat_sat", lat, 11);
    chk("clamp_hi_ch0", gate_x[15:0], 1024);
    chk("clamp_lo_ch1", gate_x[31:16], 0);
    chk("clamp_hold_ch2", gate_x[47:32], 326);
`ifdef GATE_BANK_SAT_FLAGS_EN
    chk("sat_flags_set", sat_flags, 3'b011);
`endif
    // stalled table on ch1, start pulses during busy and on the done cycle
    set_tbl(0, 0, 0, 0, 0, 0);
    stall_left = 7;
    @(negedge clk);
    v_in = 16'd77; dt = 500; start = 1;
    lat = 1;
    seen_done = 0;
    while (lat < 40 && !seen_done) begin
      @(negedge clk);
      lat++;
      start = (lat == 6);
      if (lat >= 5 && lat <= 12) begin
        chk("stall_req", rate_req, 1);
        chk("stall_ch", rate_ch, 1);
        chk("stall_v", rate_v, 77);
      end
      seen_done = done;
    end
    chk("lat_stall", lat, 18);
`ifdef GATE_BANK_SAT_FLAGS_EN
    chk("sat_flags_clr", sat_flags, 3'b000);
`endif
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_on_done_ignored", busy, 0);
    @(negedge clk);
    chk("no_extra_step", busy, 0);
    chk("stall_ch0", gate_x[15:0], 1024);
    // reset during CALC of ch1
    set_tbl(0, 1024, 0, 0, 0, 0);
    @(negedge clk);
    dt = 102; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_calc_ch", rate_ch, 1);
    chk("pre_rst_req", rate_req, 0);
    chk("pre_rst_ch0", gate_x[15:0], 922);
    reset = 1;
    #1;
    chk("mid_rst_ch0", gate_x[15:0], 54);
    chk("mid_rst_ch1", gate_x[31:16], 610);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ch", rate_ch, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      seen_done = seen_done | done | busy;
    end
    chk("post_rst_quiet", seen_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
